seq_pattern_tx: RTL and testbench
=================================

Name: seq_pattern_tx

Overview:
Bit-serial pattern transmitter. It is the driving end for the non-overlapping sequence detector ("statemachine", x→y).
- On a start request, it emits a fixed PAT_W-bit pattern (default 1011) MSB-first on serial output x, repeated N times.
- Consecutive frames are separated by GAP idle-zero cycles.
- Busy, done and state are reported so that detector benches and on-board stimulus can run without hand-written x sequences.

Parameters:
PAT_W, 4, pattern width in bits (2..16)
PATTERN, 4'b1011, transmitted pattern, bit PAT_W-1 sent first
GAP, 2, number of x=0 cycles inserted between consecutive frames (0..15); no gap after the last frame

Ports:
clk  input  1  system clock, rising-edge
rst  input  1  asynchronous, active-high reset
start  input  1  request a burst; sampled only in IDLE
repeat_cnt  input  8  frames per burst; latched when start is accepted
abort  input  1  synchronous abort of the current burst
x  output  1  serial data out (registered)
busy  output  1  high during SEND and GAP
done  output  1  one-cycle pulse after the last bit of a completed burst
frames_sent  output  8  frames completed in the current/last burst
outstate  output  2  current FSM state: IDLE=0, SEND=1, GAP=2, DONE=3

Behaviour:
- All outputs are registered. Async reset gives: x=0, busy=0, done=0, frames_sent=0, outstate=IDLE, bit index=PAT_W-1, remaining-frame count=0.
- Reset asserted mid-burst: outputs clear immediately with no done pulse. After release, the block waits in IDLE.
- IDLE:
  - x=0, busy=0.
  - start=1 with repeat_cnt!=0 at an edge: latch repeat_cnt as remaining, clear frames_sent, go to SEND. On that same edge x<=PATTERN[PAT_W-1] and busy<=1.
  - start=1 with repeat_cnt==0: ignored, stay in IDLE, no done pulse.
- SEND:
  - One bit per cycle, MSB-first: x=PATTERN[idx], idx decrements each edge.
  - At the edge leaving idx==0: frames_sent+1, remaining-1, then:
    - remaining now 0 → DONE.
    - GAP>0 → GAP.
    - GAP==0 → reload idx=PAT_W-1 and stay in SEND (back-to-back frames).
- GAP:
  - x=0 for exactly GAP cycles, then SEND with idx=PAT_W-1.
- DONE:
  - Lasts one cycle: x=0, busy=0, done=1, then IDLE.
  - A start seen during DONE is ignored.
- Timing totals for N frames:
  - busy high for N*PAT_W + (N-1)*GAP cycles.
  - done rises on the edge after the last pattern bit.
- start while busy: ignored, with no effect on the current burst or the latched count.
- abort=1 in SEND or GAP:
  - Next edge → IDLE with x=0, busy=0, no done.
  - frames_sent keeps the frames already completed.
  - abort has priority over start and over frame completion on the same edge.
  - abort in IDLE or DONE has no effect.
- frames_sent holds its value after the burst until the next accepted start. It cannot overflow because it is bounded by repeat_cnt ≤ 255.
- Illegal outstate encoding cannot arise from a 2-bit encoding with all states used. The default branch goes to IDLE.

Decomposition:
- Shared package seq_pkg:
  - State encoding constants ST_IDLE, ST_SEND, ST_GAP, ST_DONE (2 bits), shared with the detector's outstate decoding.
  - Default pattern constant PAT_1011.
- One natural sub-module, tx_down_counter: loadable, parameter-width down-counter with a zero flag.
  - Used twice: once for the bit index / gap timer, once for the remaining-frame count.

Test Plan:
- Reset then start=1 for one cycle, repeat_cnt=3, GAP=2 → x over 16 busy cycles = 1,0,1,1,0,0,1,0,1,1,0,0,1,0,1,1. Then done=1 for one cycle; frames_sent=3; outstate returns to 0.
- Same stimulus looped into the detector x input → detector y asserts exactly 3 times.
- GAP=0, repeat_cnt=2 → x=1,0,1,1,1,0,1,1 with busy high for 8 cycles and no idle bit between frames.
- start with repeat_cnt=0 → no busy, no done, x stays 0. Then start pulses during busy of a repeat_cnt=1 burst → exactly one frame (busy 4 cycles), frames_sent=1.
- abort on the 2nd bit of frame 2 (repeat_cnt=4) → IDLE next edge, x=0, no done, frames_sent=1.
- rst asserted asynchronously mid-GAP (between clock edges) → x, busy, done, frames_sent go to 0 immediately. A new start after release produces a clean burst beginning with x=1.

Source files
------------

// File: rtl/seq_pkg.sv
// Shared definitions for the pattern transmitter and its companion sequence detector.
package seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_GAP  = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    localparam logic [3:0] PAT_1011 = 4'b1011;

    // Wide enough for a bit index of a 16-bit pattern and for a 15-cycle gap.
    localparam int CNT_W = 4;

    function automatic logic pattern_bit(input logic [15:0] pat, input logic [CNT_W-1:0] idx);
        return pat[idx];
    endfunction

endpackage

// File: rtl/tx_down_counter.sv
// Loadable down-counter with a zero flag; load takes priority over decrement.
module tx_down_counter #(
    parameter int             W       = 8,
    parameter logic [W-1:0]   RST_VAL = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         dec_i,
    output logic [W-1:0] cnt_o,
    output logic         zero_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // NOTE: every signal driven in always_comb gets a default first, so no path leaves it unassigned (no latch).
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= RST_VAL;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o  = cnt_q;
    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/seq_pattern_tx.sv
// Bit-serial transmitter: sends PATTERN MSB-first, repeated N times with GAP idle-zero cycles between frames.
module seq_pattern_tx
    import seq_pkg::*;
#(
    parameter int               PAT_W   = 4,
    parameter logic [PAT_W-1:0] PATTERN = PAT_1011,
    parameter int               GAP     = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] repeat_cnt,
    input  logic       abort,
    output logic       x,
    output logic       busy,
    output logic       done,
    output logic [7:0] frames_sent,
    output logic [1:0] outstate
);

    localparam logic [15:0]      PAT_EXT = 16'(PATTERN);
    localparam logic [CNT_W-1:0] IDX_TOP = CNT_W'(PAT_W - 1);
    localparam logic [CNT_W-1:0] GAP_TOP = (GAP > 0) ? CNT_W'(GAP - 1) : '0;
    localparam bit               HAS_GAP = (GAP > 0);

    state_e     state_q, state_d;
    logic       x_q, x_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic [7:0] frames_q, frames_d;

    logic             idx_load, idx_dec, idx_zero;
    logic [CNT_W-1:0] idx_val, idx_cnt;
    logic             rem_load, rem_dec, rem_zero;
    logic [7:0]       rem_cnt;

    // Shared between the bit index (SEND) and the gap timer (GAP); each state reloads it on entry.
    tx_down_counter #(.W(CNT_W), .RST_VAL(IDX_TOP)) u_idx_cnt (
        .clk        (clk),
        .rst        (rst),
        .load_i     (idx_load),
        .load_val_i (idx_val),
        .dec_i      (idx_dec),
        .cnt_o      (idx_cnt),
        .zero_o     (idx_zero)
    );

    tx_down_counter #(.W(8), .RST_VAL(8'd0)) u_rem_cnt (
        .clk        (clk),
        .rst        (rst),
        .load_i     (rem_load),
        .load_val_i (repeat_cnt),
        .dec_i      (rem_dec),
        .cnt_o      (rem_cnt),
        .zero_o     (rem_zero)
    );

    always_comb begin
        state_d  = state_q;
        x_d      = 1'b0;
        busy_d   = 1'b0;
        done_d   = 1'b0;
        frames_d = frames_q;
        idx_load = 1'b0;
        idx_val  = IDX_TOP;
        idx_dec  = 1'b0;
        rem_load = 1'b0;
        rem_dec  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                idx_load = 1'b1;
                if (start && repeat_cnt != 8'd0) begin
                    state_d  = ST_SEND;
                    x_d      = pattern_bit(PAT_EXT, IDX_TOP);
                    busy_d   = 1'b1;
                    frames_d = 8'd0;
                    rem_load = 1'b1;
                end
            end

            ST_SEND: begin
                if (abort) begin
                    state_d  = ST_IDLE;
                    idx_load = 1'b1;
                end else if (idx_zero) begin
                    frames_d = frames_q + 8'd1;
                    rem_dec  = !rem_zero;
                    idx_load = 1'b1;
                    if (rem_cnt == 8'd1) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                    end else if (HAS_GAP) begin
                        state_d = ST_GAP;
                        busy_d  = 1'b1;
                        idx_val = GAP_TOP;
                    end else begin
                        busy_d = 1'b1;
                        x_d    = pattern_bit(PAT_EXT, IDX_TOP);
                    end
                end else begin
                    busy_d  = 1'b1;
                    idx_dec = 1'b1;
                    x_d     = pattern_bit(PAT_EXT, idx_cnt - CNT_W'(1));
                end
            end

            ST_GAP: begin
                if (abort) begin
                    state_d  = ST_IDLE;
                    idx_load = 1'b1;
                end else if (idx_zero) begin
                    state_d  = ST_SEND;
                    busy_d   = 1'b1;
                    idx_load = 1'b1;
                    x_d      = pattern_bit(PAT_EXT, IDX_TOP);
                end else begin
                    busy_d  = 1'b1;
                    idx_dec = 1'b1;
                end
            end

            ST_DONE: begin
                state_d  = ST_IDLE;
                idx_load = 1'b1;
            end

            default: begin
                state_d  = ST_IDLE;
                idx_load = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            x_q      <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            frames_q <= 8'd0;
        end else begin
            state_q  <= state_d;
            x_q      <= x_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            frames_q <= frames_d;
        end
    end

    assign x           = x_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign frames_sent = frames_q;
    assign outstate    = state_q;

endmodule

// File: tb/tb_seq_pattern_tx.sv
// Self-checking bench: two transmitters (GAP=2 and GAP=0) against a position-based burst model.
module tb_seq_pattern_tx;

    localparam int         PAT_W = 4;
    localparam logic [3:0] PAT   = 4'b1011;

    int gap_v [2] = '{2, 0};

    logic       clk   = 1'b0;
    logic       rst   = 1'b1;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic [7:0] rc    = 8'd0;

    logic [1:0] x_w, busy_w, done_w;
    logic [7:0] fs_w [2];
    logic [1:0] st_w [2];

    always #5 clk = ~clk;

    seq_pattern_tx #(.PAT_W(4), .PATTERN(4'b1011), .GAP(2)) u_gap2 (
        .clk(clk), .rst(rst), .start(start), .repeat_cnt(rc), .abort(abort),
        .x(x_w[0]), .busy(busy_w[0]), .done(done_w[0]),
        .frames_sent(fs_w[0]), .outstate(st_w[0])
    );

    seq_pattern_tx #(.PAT_W(4), .PATTERN(4'b1011), .GAP(0)) u_gap0 (
        .clk(clk), .rst(rst), .start(start), .repeat_cnt(rc), .abort(abort),
        .x(x_w[1]), .busy(busy_w[1]), .done(done_w[1]),
        .frames_sent(fs_w[1]), .outstate(st_w[1])
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Model: a burst is a position counter over a timeline of N frames of (PAT_W bits + GAP zeros),
    // minus the trailing gap, followed by one done cycle.
    typedef struct packed {
        logic       x;
        logic       busy;
        logic       done;
        logic [1:0] st;
        logic [7:0] fr;
    } exp_t;

    int m_active [2];
    int m_n      [2];
    int m_pos    [2];
    int m_held   [2];

    function automatic int burst_len(int i);
        return m_n[i] * PAT_W + (m_n[i] - 1) * gap_v[i];
    endfunction

    function automatic exp_t predict(int i);
        exp_t e;
        int   len, f, off;
        e = '0;
        if (m_active[i] == 0) begin
            e.fr = 8'(m_held[i]);
            return e;
        end
        if (m_pos[i] == burst_len(i)) begin
            e.done = 1'b1;
            e.st   = 2'd3;
            e.fr   = 8'(m_n[i]);
            return e;
        end
        len    = PAT_W + gap_v[i];
        f      = m_pos[i] / len;
        off    = m_pos[i] % len;
        e.busy = 1'b1;
        if (off < PAT_W) begin
            e.x  = PAT[PAT_W - 1 - off];
            e.st = 2'd1;
            e.fr = 8'(f);
        end else begin
            e.st = 2'd2;
            e.fr = 8'(f + 1);
        end
        return e;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_active[i] = 0;
            m_n[i]      = 0;
            m_pos[i]    = 0;
            m_held[i]   = 0;
        end
    endtask

    task automatic model_step();
        exp_t e;
        for (int i = 0; i < 2; i++) begin
            if (m_active[i] != 0) begin
                e = predict(i);
                if (abort && (e.st == 2'd1 || e.st == 2'd2)) begin
                    m_held[i]   = int'(e.fr);
                    m_active[i] = 0;
                end else begin
                    m_pos[i]++;
                    if (m_pos[i] > burst_len(i)) begin
                        m_active[i] = 0;
                        m_held[i]   = m_n[i];
                    end
                end
            end else if (start && rc != 8'd0) begin
                m_active[i] = 1;
                m_n[i]      = int'(rc);
                m_pos[i]    = 0;
            end
        end
    endtask

    task automatic compare_all();
        exp_t e;
        for (int i = 0; i < 2; i++) begin
            e = predict(i);
            check($sformatf("x_g%0d", gap_v[i]),      32'(x_w[i]),    32'(e.x));
            check($sformatf("busy_g%0d", gap_v[i]),   32'(busy_w[i]), 32'(e.busy));
            check($sformatf("done_g%0d", gap_v[i]),   32'(done_w[i]), 32'(e.done));
            check($sformatf("frames_g%0d", gap_v[i]), 32'(fs_w[i]),   32'(e.fr));
            check($sformatf("state_g%0d", gap_v[i]),  32'(st_w[i]),   32'(e.st));
        end
    endtask

    // Per-burst capture used by the hand-computed expectations.
    logic [63:0] capv     [2];
    int          ncap     [2];
    int          done_cnt [2];

    task automatic clr_cap();
        for (int i = 0; i < 2; i++) begin
            capv[i]     = '0;
            ncap[i]     = 0;
            done_cnt[i] = 0;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        if (!rst) model_step();
        @(negedge clk);
        compare_all();
        for (int i = 0; i < 2; i++) begin
            if (busy_w[i] === 1'b1) begin
                capv[i] = {capv[i][62:0], x_w[i]};
                ncap[i]++;
            end
            if (done_w[i] === 1'b1) done_cnt[i]++;
        end
    endtask

    // Independent non-overlapping 1011 detector over the captured GAP=2 stream.
    function automatic int count_1011();
        int cnt = 0;
        int k   = ncap[0] - 1;
        while (k >= 3) begin
            if (capv[0][k -: 4] == 4'b1011) begin
                cnt++;
                k -= 4;
            end else begin
                k--;
            end
        end
        return cnt;
    endfunction

    initial begin
        model_reset();
        clr_cap();

        repeat (2) tick();
        check("rst_state", 32'(st_w[0]), 32'd0);
        check("rst_frames", 32'(fs_w[0]), 32'd0);
        rst = 1'b0;
        repeat (2) tick();

        // Three frames, GAP=2 and GAP=0 side by side.
        start = 1'b1; rc = 8'd3;
        tick();
        start = 1'b0;
        repeat (24) tick();
        check("t1_busy_cycles_g2", 32'(ncap[0]), 32'd16);
        check("t1_xseq_g2", 32'(capv[0][15:0]), 32'h0000_B2CB);
        check("t1_done_g2", 32'(done_cnt[0]), 32'd1);
        check("t1_frames_g2", 32'(fs_w[0]), 32'd3);
        check("t1_idle_g2", 32'(st_w[0]), 32'd0);
        check("t1_detect_hits", 32'(count_1011()), 32'd3);
        check("t1_xseq_g0", 32'(capv[1][11:0]), 32'h0000_0BBB);

        // Two back-to-back frames with no gap.
        clr_cap();
        start = 1'b1; rc = 8'd2;
        tick();
        start = 1'b0;
        repeat (16) tick();
        check("t2_busy_cycles_g0", 32'(ncap[1]), 32'd8);
        check("t2_xseq_g0", 32'(capv[1][7:0]), 32'h0000_00BB);
        check("t2_done_g0", 32'(done_cnt[1]), 32'd1);
        check("t2_busy_cycles_g2", 32'(ncap[0]), 32'd10);

        // Zero repeat count is ignored.
        clr_cap();
        start = 1'b1; rc = 8'd0;
        repeat (6) tick();
        start = 1'b0;
        check("t3_zero_busy", 32'(ncap[0] + ncap[1]), 32'd0);
        check("t3_zero_done", 32'(done_cnt[0] + done_cnt[1]), 32'd0);

        // Single frame with start held through busy and done.
        clr_cap();
        start = 1'b1; rc = 8'd1;
        tick();
        rc = 8'd5;
        repeat (5) tick();
        start = 1'b0;
        repeat (6) tick();
        for (int i = 0; i < 2; i++) begin
            check($sformatf("t3_one_busy_%0d", i), 32'(ncap[i]), 32'd4);
            check($sformatf("t3_one_xseq_%0d", i), 32'(capv[i][3:0]), 32'h0000_000B);
            check($sformatf("t3_one_done_%0d", i), 32'(done_cnt[i]), 32'd1);
            check($sformatf("t3_one_frames_%0d", i), 32'(fs_w[i]), 32'd1);
        end

        // Abort on the second bit of frame 2 (GAP=2); on the last bit of frame 2 for GAP=0.
        clr_cap();
        start = 1'b1; rc = 8'd4;
        tick();
        start = 1'b0;
        repeat (7) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        for (int i = 0; i < 2; i++) begin
            check($sformatf("t4_abort_busy_%0d", i), 32'(busy_w[i]), 32'd0);
            check($sformatf("t4_abort_x_%0d", i), 32'(x_w[i]), 32'd0);
            check($sformatf("t4_abort_state_%0d", i), 32'(st_w[i]), 32'd0);
            check($sformatf("t4_abort_frames_%0d", i), 32'(fs_w[i]), 32'd1);
        end
        repeat (10) tick();
        check("t4_no_done", 32'(done_cnt[0] + done_cnt[1]), 32'd0);
        abort = 1'b1;
        repeat (3) tick();
        abort = 1'b0;

        // Asynchronous reset in the middle of a gap.
        clr_cap();
        start = 1'b1; rc = 8'd3;
        tick();
        start = 1'b0;
        repeat (4) tick();
        check("t5_in_gap", 32'(st_w[0]), 32'd2);
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        compare_all();
        check("t5_rst_x", 32'(x_w[0]), 32'd0);
        check("t5_rst_busy", 32'(busy_w[0]), 32'd0);
        check("t5_rst_done", 32'(done_w[0]), 32'd0);
        check("t5_rst_frames", 32'(fs_w[0]), 32'd0);
        #1;
        rst = 1'b0;
        start = 1'b1; rc = 8'd2;
        tick();
        start = 1'b0;
        check("t5_restart_x", 32'(x_w[0]), 32'd1);
        check("t5_restart_busy", 32'(busy_w[0]), 32'd1);
        repeat (20) tick();

        // Randomized traffic: starts, varied counts, aborts and occasional resets.
        repeat (600) begin
            start = ($urandom_range(0, 7) == 0);
            rc    = 8'($urandom_range(0, 4));
            abort = ($urandom_range(0, 24) == 0);
            if ($urandom_range(0, 149) == 0) begin
                rst = 1'b1;
                model_reset();
            end else begin
                rst = 1'b0;
            end
            tick();
        end
        start = 1'b0;
        abort = 1'b0;
        rst   = 1'b0;
        repeat (40) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
